// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl
//   Streaming 3x3 Sobel front end. Takes a raster-order 8-bit pixel stream,
//   keeps two line buffers and a 3x3 window, and emits one saturated edge
//   magnitude per interior pixel ((IMG_H-2)*(IMG_W-2) results per frame).
//
// Ports
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_start               1-cycle pulse, begins a frame when idle
//   i_pix, i_pix_valid    input pixel stream
//   o_pix_ready           controller accepts i_pix this cycle
//   o_sobel, o_sobel_valid, i_sobel_ready   result stream to the sink
//   o_busy                high while a frame is in progress
//   o_frame_done          1-cycle pulse after the last result is accepted
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until the
// transfer; ready may depend combinationally on the downstream ready.

// Sobel magnitude |gx|+|gy| of a 3x3 window, saturated to 8 bits.
// Window layout: p0 p1 p2 (top row), p3 p4 p5, p6 p7 p8 (bottom row).
module sobel_mask (
    input  logic [7:0] i_p0,
    input  logic [7:0] i_p1,
    input  logic [7:0] i_p2,
    input  logic [7:0] i_p3,
    input  logic [7:0] i_p5,
    input  logic [7:0] i_p6,
    input  logic [7:0] i_p7,
    input  logic [7:0] i_p8,
    output logic [7:0] o_mag
);
    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic [10:0]        abs_gx;
    logic [10:0]        abs_gy;
    logic [11:0]        sum;

    function automatic logic signed [10:0] ext(input logic [7:0] p);
        return $signed({3'b000, p});
    endfunction

    always_comb begin
        gx = (ext(i_p2) + (ext(i_p5) <<< 1) + ext(i_p8))
           - (ext(i_p0) + (ext(i_p3) <<< 1) + ext(i_p6));
        gy = (ext(i_p6) + (ext(i_p7) <<< 1) + ext(i_p8))
           - (ext(i_p0) + (ext(i_p1) <<< 1) + ext(i_p2));
        abs_gx = gx[10] ? $unsigned(-gx) : $unsigned(gx);
        abs_gy = gy[10] ? $unsigned(-gy) : $unsigned(gy);
        sum    = {1'b0, abs_gx} + {1'b0, abs_gy};
        o_mag  = (sum > 12'd255) ? 8'hFF : sum[7:0];
    end
endmodule

module sobel_window_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_pix,
    input  logic       i_pix_valid,
    output logic       o_pix_ready,
    output logic [7:0] o_sobel,
    output logic       o_sobel_valid,
    input  logic       i_sobel_ready,
    output logic       o_busy,
    output logic       o_frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    win_q [9];
    logic [7:0]    win_d [9];
    logic          s1_valid_q, s1_valid_d;
    logic [7:0]    sobel_q, sobel_d;
    logic          sobel_valid_q, sobel_valid_d;
    logic          frame_done_q, frame_done_d;

    // Line buffers: linebuf0 holds row r-1, linebuf1 holds row r-2 at the
    // current column. Not reset; every entry is written before it is read.
    logic [7:0]    linebuf0_q [IMG_W];
    logic [7:0]    linebuf1_q [IMG_W];
    logic [7:0]    lb0_rd;
    logic [7:0]    lb1_rd;

    logic          adv;
    logic          pix_ready;
    logic          accept;
    logic [7:0]    mag;

    // The whole pipeline freezes while a result waits on the sink.
    assign adv       = !sobel_valid_q || i_sobel_ready;
    assign pix_ready = adv && ((state_q == S_FILL) || (state_q == S_RUN));
    assign accept    = i_pix_valid && pix_ready;
    assign lb0_rd    = linebuf0_q[col_q];
    assign lb1_rd    = linebuf1_q[col_q];

    sobel_mask u_mask (
        .i_p0  (win_q[0]),
        .i_p1  (win_q[1]),
        .i_p2  (win_q[2]),
        .i_p3  (win_q[3]),
        .i_p5  (win_q[5]),
        .i_p6  (win_q[6]),
        .i_p7  (win_q[7]),
        .i_p8  (win_q[8]),
        .o_mag (mag)
    );

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        win_d         = win_q;
        s1_valid_d    = s1_valid_q;
        sobel_d       = sobel_q;
        sobel_valid_d = sobel_valid_q;
        frame_done_d  = 1'b0;

        if (adv) begin
            sobel_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sobel_d = mag;
            end
            s1_valid_d = 1'b0;
        end

        if (accept) begin
            // Shift window left; new right column is rows r-2, r-1, r.
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb1_rd;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb0_rd;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = i_pix;
            // c>=2 keeps the window from straddling a line wrap.
            s1_valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_FILL;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_FILL: begin
                if (accept && (row_q == RW'(1)) && (col_q == COL_LAST)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && (row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Done once stage 1 is empty and the output slot is empty or
                // being taken by the sink this cycle.
                if (!s1_valid_q && adv) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
            s1_valid_q    <= 1'b0;
            sobel_q       <= '0;
            sobel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            win_q         <= win_d;
            s1_valid_q    <= s1_valid_d;
            sobel_q       <= sobel_d;
            sobel_valid_q <= sobel_valid_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            linebuf1_q[col_q] <= lb0_rd;
            linebuf0_q[col_q] <= i_pix;
        end
    end

    assign o_pix_ready   = pix_ready;
    assign o_sobel       = sobel_q;
    assign o_sobel_valid = sobel_valid_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_frame_done  = frame_done_q;
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl with an 8x6 frame (24 results per frame).
// Expected results come from a direct 2-D Sobel over the stimulus image.
module tb_sobel_window_ctrl;
    localparam int W = 8;
    localparam int H = 6;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_pix = 8'h00;
    logic       i_pix_valid = 1'b0;
    logic       o_pix_ready;
    logic [7:0] o_sobel;
    logic       o_sobel_valid;
    logic       i_sobel_ready = 1'b1;
    logic       o_busy;
    logic       o_frame_done;

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_pix         (i_pix),
        .i_pix_valid   (i_pix_valid),
        .o_pix_ready   (o_pix_ready),
        .o_sobel       (o_sobel),
        .o_sobel_valid (o_sobel_valid),
        .i_sobel_ready (i_sobel_ready),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int         total = 0;
    int         bad = 0;
    logic [7:0] img [0:H-1][0:W-1];
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;
    logic [7:0] last_got = 8'h00;
    int         got_cnt = 0;
    int         done_cnt = 0;
    bit         chk_en = 1'b1;
    bit         seen_valid = 1'b0;
    int         first_valid_cyc = 0;
    int         acc_cyc = 0;
    int         pix_idx = -1;
    bit         stall_en = 1'b0;
    bit         poke_en = 1'b0;

    function automatic void chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    // ---------------- model ----------------
    task automatic fill(input int mode);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (mode)
                    0:       img[r][c] = 8'h40;
                    1:       img[r][c] = (c < 4) ? 8'h00 : 8'hFF;
                    default: img[r][c] = 8'(10 * c);
                endcase
            end
        end
    endtask

    task automatic build_expected();
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                int gx, gy, m;
                gx = (int'(img[r-1][c+1]) + 2 * int'(img[r][c+1]) + int'(img[r+1][c+1]))
                   - (int'(img[r-1][c-1]) + 2 * int'(img[r][c-1]) + int'(img[r+1][c-1]));
                gy = (int'(img[r+1][c-1]) + 2 * int'(img[r+1][c]) + int'(img[r+1][c+1]))
                   - (int'(img[r-1][c-1]) + 2 * int'(img[r-1][c]) + int'(img[r-1][c+1]));
                m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                exp_q.push_back(m > 255 ? 8'hFF : m[7:0]);
            end
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge i_clk) begin
        if (o_frame_done) done_cnt++;
        if (chk_en && !i_rst) begin
            if (o_sobel_valid && !seen_valid) begin
                seen_valid = 1'b1;
                first_valid_cyc = cyc;
            end
            if (o_sobel_valid && i_sobel_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("sobel_result", o_sobel, exp_v);
                end
                last_got = o_sobel;
                got_cnt++;
            end
        end
    end

    // Sink stall: 5 cycles with ready low, starting while results flow.
    initial begin
        wait (stall_en && got_cnt == 9);
        @(posedge i_clk); #1;
        i_sobel_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            chk("stall_pix_ready", o_pix_ready, 0);
            chk("stall_valid_held", o_sobel_valid, 1);
            chk("stall_data_held", o_sobel, exp_q[0]);
        end
        @(posedge i_clk); #1;
        i_sobel_ready = 1'b1;
        stall_en = 1'b0;
    end

    // Start pulse in the middle of a running frame must be ignored.
    initial begin
        wait (poke_en && pix_idx == 25);
        @(posedge i_clk); #1;
        i_start = 1'b1;
        @(negedge i_clk);
        chk("busy_during_start_poke", o_busy, 1);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        poke_en = 1'b0;
    end

    // ---------------- driver tasks ----------------
    task automatic start_pulse();
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic drive_pix(input logic [7:0] p, input int gap);
        int waited;
        waited = 0;
        i_pix = p;
        i_pix_valid = 1'b1;
        forever begin
            @(negedge i_clk);
            if (o_pix_ready) begin
                if (pix_idx == 18) acc_cyc = cyc;
                @(posedge i_clk); #1;
                break;
            end
            waited++;
            if (waited > 200) begin
                chk("pix_accept_timeout", 0, 1);
                @(posedge i_clk); #1;
                break;
            end
            @(posedge i_clk); #1;
        end
        if (gap > 0) begin
            i_pix_valid = 1'b0;
            repeat (gap) @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_frame(input int gap);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                pix_idx = r * W + c;
                drive_pix(img[r][c], gap);
            end
        end
        i_pix_valid = 1'b0;
        pix_idx = -1;
    endtask

    task automatic run_frame(input int gap, input bit check_lat);
        int d0, n;
        got_cnt = 0;
        seen_valid = 1'b0;
        d0 = done_cnt;
        start_pulse();
        send_frame(gap);
        n = 0;
        while (done_cnt == d0 && n < 1000) begin
            @(negedge i_clk);
            n++;
        end
        repeat (4) @(negedge i_clk);
        chk("frame_done_count", done_cnt - d0, 1);
        chk("result_count", got_cnt, 24);
        chk("queue_empty", exp_q.size(), 0);
        chk("busy_after_frame", o_busy, 0);
        if (check_lat) chk("first_valid_latency", first_valid_cyc - acc_cyc, 2);
        exp_q.delete();
        @(posedge i_clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_sobel_valid", o_sobel_valid, 0);
        chk("rst_sobel", o_sobel, 0);
        chk("rst_pix_ready", o_pix_ready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_frame_done", o_frame_done, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        i_pix_valid = 1'b1;
        @(negedge i_clk);
        chk("idle_pix_ready", o_pix_ready, 0);
        @(posedge i_clk); #1;
        i_pix_valid = 1'b0;

        // 1: flat frame
        fill(0);
        build_expected();
        chk("model_flat", exp_q[0], 8'h00);
        run_frame(0, 1'b1);

        // 2: vertical edge
        fill(1);
        build_expected();
        chk("model_edge_col1", exp_q[0], 8'h00);
        chk("model_edge_col3", exp_q[2], 8'hFF);
        chk("model_edge_col4", exp_q[3], 8'hFF);
        chk("model_edge_col6", exp_q[5], 8'h00);
        run_frame(0, 1'b0);

        // 3: horizontal ramp
        fill(2);
        build_expected();
        chk("model_ramp", exp_q[0], 8'h50);
        run_frame(0, 1'b0);
        chk("ramp_last_result", last_got, 8'h50);

        // 4: ramp with sink backpressure
        fill(2);
        build_expected();
        stall_en = 1'b1;
        run_frame(0, 1'b0);
        chk("stall_happened", stall_en, 0);

        // 5: reset mid-frame, then clean flat frame
        fill(2);
        chk_en = 1'b0;
        d0 = done_cnt;
        start_pulse();
        for (int i = 0; i < 20; i++) begin
            pix_idx = i;
            drive_pix(img[i / W][i % W], 0);
        end
        pix_idx = -1;
        i_pix_valid = 1'b0;
        i_rst = 1'b1;
        i_start = 1'b1;
        @(negedge i_clk);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_sobel_valid", o_sobel_valid, 0);
        chk("midrst_pix_ready", o_pix_ready, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("after_rst_busy", o_busy, 0);
        chk("aborted_no_done", done_cnt - d0, 0);
        @(posedge i_clk); #1;
        exp_q.delete();
        chk_en = 1'b1;
        fill(0);
        build_expected();
        run_frame(0, 1'b0);

        // 6: start pulse mid-frame plus 3-cycle input gaps
        fill(2);
        build_expected();
        poke_en = 1'b1;
        run_frame(3, 1'b0);
        chk("poke_happened", poke_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
